// File: rtl/shmem_arbiter.sv
// Purpose: two-master arbiter onto one single-port shared memory, round-robin with per-master bus lock.
// Latency: grant and memory command are combinational in the request cycle; read data is valid one cycle after grant.
// Backpressure: a non-granted or locked-out master is held with waitrequest=1; pipelined reads sustain one per cycle.
module shmem_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 64,
    parameter int LOCK_MAX = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic                  m0_lock,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_waitrequest,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic                  m1_lock,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_waitrequest,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,

    output logic                  lock_timeout
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    // Counter value on the cycle before it would reach LOCK_MAX; the
    // forced release happens on the same edge that the count reaches it.
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [CNT_W-1:0] IDLE_SAT  = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {RR, LOCK0, LOCK1} state_t;

    state_t            state;
    logic              rr_ptr;      // 0: m0 wins a tie, 1: m1 wins a tie
    logic [CNT_W-1:0]  idle_cnt;
    logic              rd_pend0;
    logic              rd_pend1;

    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic              owner_req;
    logic              owner_lock;

    // A read+write from one master counts as a single (write) request.
    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Request and lock qualifier of whichever master currently owns the lock.
    assign owner_req  = (state == LOCK1) ? req1    : req0;
    assign owner_lock = (state == LOCK1) ? m1_lock : m0_lock;

    // Grant decision: round-robin tie-break in RR, exclusive owner while locked, nothing in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state)
                RR: begin
                    if (req0 && req1) begin
                        gnt0 = ~rr_ptr;
                        gnt1 =  rr_ptr;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                LOCK0:   gnt0 = req0;
                LOCK1:   gnt1 = req1;
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
    end

    // Steer the granted master's command onto the memory port.
    always_comb begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        mem_write      = 1'b0;
        if (gnt1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end else if (gnt0) begin
            mem_write      = m0_write;
        end
    end

    assign mem_chipselect = gnt0 | gnt1;
    assign mem_clken      = 1'b1;

    // Waitrequest drops only for a requesting master that holds the grant.
    assign m0_waitrequest = ~(req0 & gnt0);
    assign m1_waitrequest = ~(req1 & gnt1);

    // Read data is broadcast; readdatavalid alone tells each master it is theirs.
    assign m0_readdata = mem_readdata;
    assign m1_readdata = mem_readdata;

    // Valid is masked during reset so a read granted just before reset never completes.
    assign m0_readdatavalid = rd_pend0 & ~reset;
    assign m1_readdatavalid = rd_pend1 & ~reset;

    // One-deep read-return pipeline matching the memory's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
        end else begin
            rd_pend0 <= gnt0 & m0_read & ~m0_write;
            rd_pend1 <= gnt1 & m1_read & ~m1_write;
        end
    end

    // Lock FSM, round-robin pointer, idle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RR;
            rr_ptr       <= 1'b0;
            idle_cnt     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            // Every grant hands the next tie to the other master.
            if (gnt0) begin
                rr_ptr <= 1'b1;
            end else if (gnt1) begin
                rr_ptr <= 1'b0;
            end

            case (state)
                RR: begin
                    idle_cnt <= '0;
                    if (gnt0 && m0_lock) begin
                        state <= LOCK0;
                    end else if (gnt1 && m1_lock) begin
                        state <= LOCK1;
                    end
                end
                LOCK0, LOCK1: begin
                    // While locked the owner's request is always granted,
                    // so owner_req here means a granted transfer.
                    if (owner_req) begin
                        idle_cnt <= '0;
                        if (!owner_lock) begin
                            state <= RR;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        idle_cnt     <= IDLE_SAT;
                        state        <= RR;
                        lock_timeout <= 1'b1;
                    end else if (idle_cnt != IDLE_SAT) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shmem_arbiter.sv
// Purpose: directed bench for shmem_arbiter with a behavioural one-cycle-latency memory.
// Latency: stimulus changes 1 unit after posedge; grant checks and the read monitor sample on negedge.
// Backpressure: expected read data is queued per master and popped by the monitor on readdatavalid.
module tb_shmem_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 64;
    localparam int BE_W   = DATA_W / 8;

    logic                clk = 1'b0;
    logic                reset;

    logic [ADDR_W-1:0]   m0_address;
    logic [BE_W-1:0]     m0_byteenable;
    logic                m0_read;
    logic                m0_write;
    logic [DATA_W-1:0]   m0_writedata;
    logic                m0_lock;
    logic [DATA_W-1:0]   m0_readdata;
    logic                m0_waitrequest;
    logic                m0_readdatavalid;

    logic [ADDR_W-1:0]   m1_address;
    logic [BE_W-1:0]     m1_byteenable;
    logic                m1_read;
    logic                m1_write;
    logic [DATA_W-1:0]   m1_writedata;
    logic                m1_lock;
    logic [DATA_W-1:0]   m1_readdata;
    logic                m1_waitrequest;
    logic                m1_readdatavalid;

    logic [ADDR_W-1:0]   mem_address;
    logic [BE_W-1:0]     mem_byteenable;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;
    logic                lock_timeout;

    logic [DATA_W-1:0]   mem [0:127];

    logic [DATA_W-1:0]   exp0 [$];
    logic [DATA_W-1:0]   exp1 [$];
    logic [DATA_W-1:0]   e0;
    logic [DATA_W-1:0]   e1;

    int checks = 0;
    int errors = 0;

    shmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LOCK_MAX (64)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_lock          (m0_lock),
        .m0_readdata      (m0_readdata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_lock          (m1_lock),
        .m1_readdata      (m1_readdata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .lock_timeout     (lock_timeout)
    );

    always #5 clk = ~clk;

    // Memory model: word i holds 0x1000_0000_0000_0000 + i after reset,
    // byte-enabled writes, registered read data one cycle after the command.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) begin
                mem[i] <= 64'h1000_0000_0000_0000 + 64'(i);
            end
        end else if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (mem_byteenable[b]) begin
                        mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                    end
                end
            end else begin
                mem_readdata <= mem[mem_address];
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_m0(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be, input logic lk);
        m0_read = rd; m0_write = wr; m0_address = a;
        m0_writedata = d; m0_byteenable = be; m0_lock = lk;
    endtask

    task automatic set_m1(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be, input logic lk);
        m1_read = rd; m1_write = wr; m1_address = a;
        m1_writedata = d; m1_byteenable = be; m1_lock = lk;
    endtask

    task automatic idle_all();
        set_m0(1'b0, 1'b0, '0, '0, '0, 1'b0);
        set_m1(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every readdatavalid must match the oldest expected word for that master.
    always @(negedge clk) begin
        if (m0_readdatavalid) begin
            if (exp0.size() == 0) begin
                chk1("m0_spurious_rdv", m0_readdatavalid, 1'b0);
            end else begin
                e0 = exp0.pop_front();
                chk64("m0_readdata", m0_readdata, e0);
            end
        end
        if (m1_readdatavalid) begin
            if (exp1.size() == 0) begin
                chk1("m1_spurious_rdv", m1_readdatavalid, 1'b0);
            end else begin
                e1 = exp1.pop_front();
                chk64("m1_readdata", m1_readdata, e1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        // Reset with requests present: nothing may be granted.
        reset = 1'b1;
        idle_all();
        set_m0(1'b1, 1'b0, 7'd5, '0, 8'hFF, 1'b0);
        set_m1(1'b0, 1'b1, 7'd9, 64'h1, 8'hFF, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_m0_wait", m0_waitrequest, 1'b1);
        chk1("rst_m1_wait", m1_waitrequest, 1'b1);
        chk1("rst_m0_rdv", m0_readdatavalid, 1'b0);
        chk1("rst_m1_rdv", m1_readdatavalid, 1'b0);
        chk1("rst_cs", mem_chipselect, 1'b0);
        chk1("rst_wr", mem_write, 1'b0);
        chk1("rst_clken", mem_clken, 1'b1);
        chk1("rst_lock_timeout", lock_timeout, 1'b0);

        // Both read addr 5 right after reset: m0 first, then m1.
        next_cycle();
        reset = 1'b0;
        set_m0(1'b1, 1'b0, 7'd5, '0, 8'hFF, 1'b0);
        set_m1(1'b1, 1'b0, 7'd5, '0, 8'hFF, 1'b0);
        @(negedge clk);
        chk1("tie_c0_m0_wait", m0_waitrequest, 1'b0);
        chk1("tie_c0_m1_wait", m1_waitrequest, 1'b1);
        chk1("tie_c0_cs", mem_chipselect, 1'b1);
        chk1("tie_c0_wr", mem_write, 1'b0);
        chk64("tie_c0_addr", 64'(mem_address), 64'd5);
        exp0.push_back(64'h1000_0000_0000_0005);
        next_cycle();
        set_m0(1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        chk1("tie_c1_m1_wait", m1_waitrequest, 1'b0);
        chk1("tie_c1_m0_rdv", m0_readdatavalid, 1'b1);
        exp1.push_back(64'h1000_0000_0000_0005);
        next_cycle();
        idle_all();
        @(negedge clk);
        chk1("tie_c2_m1_rdv", m1_readdatavalid, 1'b1);
        chk1("tie_c2_cs", mem_chipselect, 1'b0);

        // m0 streams writes, m1 streams reads: grants alternate, m0 first.
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            set_m0(1'b0, 1'b1, 7'd20, 64'h5555_6666_7777_8888, 8'hFF, 1'b0);
            set_m1(1'b1, 1'b0, 7'd10, '0, 8'hFF, 1'b0);
            @(negedge clk);
            chk1("alt_m0_wait", m0_waitrequest, (k % 2 == 1));
            chk1("alt_m1_wait", m1_waitrequest, (k % 2 == 0));
            chk1("alt_mem_write", mem_write, (k % 2 == 0));
            if (k % 2 == 1) exp1.push_back(64'h1000_0000_0000_000A);
        end
        next_cycle();
        idle_all();
        @(negedge clk);

        // m1 locks with a read, idles, then unlocks with a write; m0 waits throughout.
        next_cycle();
        set_m1(1'b1, 1'b0, 7'd4, '0, 8'hFF, 1'b1);
        @(negedge clk);
        chk1("lk_c0_m1_wait", m1_waitrequest, 1'b0);
        exp1.push_back(64'h1000_0000_0000_0004);
        next_cycle();
        set_m0(1'b1, 1'b0, 7'd3, '0, 8'hFF, 1'b0);
        set_m1(1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        chk1("lk_c1_m0_wait", m0_waitrequest, 1'b1);
        chk1("lk_c1_cs", mem_chipselect, 1'b0);
        next_cycle();
        set_m1(1'b0, 1'b1, 7'd30, 64'h3030_3030_3030_3030, 8'hFF, 1'b0);
        @(negedge clk);
        chk1("lk_c2_m0_wait", m0_waitrequest, 1'b1);
        chk1("lk_c2_m1_wait", m1_waitrequest, 1'b0);
        chk1("lk_c2_wr", mem_write, 1'b1);
        next_cycle();
        set_m1(1'b1, 1'b0, 7'd4, '0, 8'hFF, 1'b0);
        @(negedge clk);
        chk1("lk_c3_m0_wait", m0_waitrequest, 1'b0);
        chk1("lk_c3_m1_wait", m1_waitrequest, 1'b1);
        exp0.push_back(64'h1000_0000_0000_0003);
        next_cycle();
        set_m0(1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        chk1("lk_c4_m1_wait", m1_waitrequest, 1'b0);
        exp1.push_back(64'h1000_0000_0000_0004);
        next_cycle();
        idle_all();
        @(negedge clk);

        // m0 locks and goes idle; m1 is starved until the 64-cycle timeout.
        next_cycle();
        set_m0(1'b1, 1'b0, 7'd6, '0, 8'hFF, 1'b1);
        set_m1(1'b1, 1'b0, 7'd7, '0, 8'hFF, 1'b0);
        @(negedge clk);
        chk1("to_c0_m0_wait", m0_waitrequest, 1'b0);
        chk1("to_c0_m1_wait", m1_waitrequest, 1'b1);
        exp0.push_back(64'h1000_0000_0000_0006);
        for (int k = 1; k <= 64; k++) begin
            next_cycle();
            set_m0(1'b0, 1'b0, '0, '0, '0, 1'b0);
            @(negedge clk);
            chk1("to_m1_held", m1_waitrequest, 1'b1);
            chk1("to_flag_low", lock_timeout, 1'b0);
        end
        next_cycle();
        @(negedge clk);
        chk1("to_c65_m1_wait", m1_waitrequest, 1'b0);
        chk1("to_c65_flag", lock_timeout, 1'b1);
        exp1.push_back(64'h1000_0000_0000_0007);
        next_cycle();
        idle_all();
        @(negedge clk);

        // Partial write to addr 127, read it back, then read earlier writes.
        next_cycle();
        set_m0(1'b0, 1'b1, 7'd127, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1'b0);
        @(negedge clk);
        chk1("be_c0_m0_wait", m0_waitrequest, 1'b0);
        chk1("be_c0_wr", mem_write, 1'b1);
        chk64("be_c0_be", 64'(mem_byteenable), 64'h0F);
        chk64("be_c0_addr", 64'(mem_address), 64'd127);
        chk64("be_c0_wdata", mem_writedata, 64'hDEAD_BEEF_CAFE_F00D);
        next_cycle();
        set_m0(1'b1, 1'b0, 7'd127, '0, 8'hFF, 1'b0);
        @(negedge clk);
        chk1("be_c1_m0_wait", m0_waitrequest, 1'b0);
        exp0.push_back(64'h1000_0000_CAFE_F00D);
        next_cycle();
        set_m0(1'b1, 1'b0, 7'd20, '0, 8'hFF, 1'b0);
        set_m1(1'b1, 1'b0, 7'd30, '0, 8'hFF, 1'b0);
        @(negedge clk);
        chk1("be_c2_m0_wait", m0_waitrequest, 1'b1);
        chk1("be_c2_m1_wait", m1_waitrequest, 1'b0);
        exp1.push_back(64'h3030_3030_3030_3030);
        next_cycle();
        set_m1(1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        chk1("be_c3_m0_wait", m0_waitrequest, 1'b0);
        exp0.push_back(64'h5555_6666_7777_8888);
        next_cycle();
        idle_all();
        @(negedge clk);

        // Reset one cycle after a granted read: the read never completes.
        next_cycle();
        set_m0(1'b1, 1'b0, 7'd5, '0, 8'hFF, 1'b0);
        @(negedge clk);
        chk1("rr_c0_m0_wait", m0_waitrequest, 1'b0);
        next_cycle();
        reset = 1'b1;
        set_m0(1'b0, 1'b0, '0, '0, '0, 1'b0);
        set_m1(1'b1, 1'b0, 7'd5, '0, 8'hFF, 1'b0);
        @(negedge clk);
        chk1("rr_c1_m0_rdv", m0_readdatavalid, 1'b0);
        chk1("rr_c1_m1_rdv", m1_readdatavalid, 1'b0);
        chk1("rr_c1_m0_wait", m0_waitrequest, 1'b1);
        chk1("rr_c1_m1_wait", m1_waitrequest, 1'b1);
        chk1("rr_c1_cs", mem_chipselect, 1'b0);
        chk1("rr_c1_wr", mem_write, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("rr_c2_m0_rdv", m0_readdatavalid, 1'b0);
        chk1("rr_c2_flag_cleared", lock_timeout, 1'b0);
        next_cycle();
        reset = 1'b0;
        set_m0(1'b1, 1'b0, 7'd5, '0, 8'hFF, 1'b0);
        set_m1(1'b1, 1'b0, 7'd7, '0, 8'hFF, 1'b0);
        @(negedge clk);
        chk1("rr_c3_m0_wait", m0_waitrequest, 1'b0);
        chk1("rr_c3_m1_wait", m1_waitrequest, 1'b1);
        exp0.push_back(64'h1000_0000_0000_0005);
        next_cycle();
        set_m0(1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        chk1("rr_c4_m1_wait", m1_waitrequest, 1'b0);
        exp1.push_back(64'h1000_0000_0000_0007);
        next_cycle();
        idle_all();
        repeat (3) @(negedge clk);

        chk64("m0_queue_drained", 64'(exp0.size()), 64'd0);
        chk64("m1_queue_drained", 64'(exp1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shmem_arbiter.md
SHMEM_ARBITER -- requirements
Module: shmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, word address width of the shared memory port.
REQ-002 SHALL have parameter DATA_W, default 64, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter LOCK_MAX, default 64, maximum consecutive idle cycles a lock is held before forced release.
REQ-004 SHALL have port clk  in  1  the single clock for all logic.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports mN_address  in  ADDR_W, mN_byteenable  in  DATA_W/8, mN_read  in  1, mN_write  in  1, mN_writedata  in  DATA_W, mN_lock  in  1, for each master N in {0,1}.
REQ-007 SHALL have ports mN_readdata  out  DATA_W, mN_waitrequest  out  1, mN_readdatavalid  out  1, for each N in {0,1}.
REQ-008 SHALL have memory-side ports mem_address  out  ADDR_W, mem_byteenable  out  DATA_W/8, mem_chipselect  out  1, mem_write  out  1, mem_writedata  out  DATA_W, mem_clken  out  1 (constant 1), mem_readdata  in  DATA_W.
REQ-009 SHALL have port lock_timeout  out  1, sticky flag, forced lock release occurred.

Function
REQ-010 A master requests in a cycle when mN_read or mN_write is 1; read and write together from one master is illegal and SHALL be treated as a write.
REQ-011 At most one master SHALL be granted per cycle; the grant is combinational from the current requests and state.
REQ-012 The granted master's command SHALL drive mem_* in the same cycle, with mem_chipselect=1 and mem_write=mN_write; with no grant, mem_chipselect=0, mem_write=0.
REQ-013 mN_waitrequest SHALL be 0 exactly in cycles where master N requests and is granted; a requesting non-granted master sees 1; a non-requesting master sees 1.
REQ-014 For a granted read in cycle T, mN_readdatavalid SHALL be 1 in cycle T+1 with mN_readdata = mem_readdata; back-to-back reads are fully pipelined, one per cycle.
REQ-015 mN_readdata SHALL be mem_readdata unconditionally; only readdatavalid qualifies it.
REQ-016 FSM states: RR, LOCK0, LOCK1.
REQ-017 In RR, with one requester, that requester SHALL win; with both, the master not granted most recently SHALL win (1-bit pointer, updated on every grant).
REQ-018 In RR, a granted transfer with mN_lock=1 SHALL move the state to LOCKN at the next edge.
REQ-019 In LOCKN, only master N SHALL be granted; the other master is held with waitrequest=1.
REQ-020 In LOCKN, a granted transfer from N with mN_lock=0 SHALL return the state to RR, with the pointer favouring the other master.
REQ-021 In LOCKN, an idle counter SHALL count cycles with no request from N, clear on any request from N, and saturate at LOCK_MAX.
REQ-022 When the idle counter reaches LOCK_MAX, the state SHALL return to RR at the next edge and set lock_timeout=1; lock_timeout clears only on reset.
REQ-023 A granted transfer with lock=1 while already in LOCKN SHALL keep LOCKN and clear the idle counter.
REQ-024 Writes SHALL have no response; the write is complete in the grant cycle.

Reset
REQ-025 While reset=1: m0/m1_waitrequest=1, m0/m1_readdatavalid=0, mem_chipselect=0, mem_write=0; no grant is issued.
REQ-026 After reset: state=RR, pointer favours m0, idle counter=0, lock_timeout=0, and the pending-read pipeline is cleared.
REQ-027 Reset asserted in the cycle after a granted read SHALL suppress that read's readdatavalid.

Verification
REQ-028 Both masters read addr 5 in the same cycle after reset -> m0 granted in T0, readdatavalid in T1; m1 granted in T1, readdatavalid in T2.
REQ-029 m0 continuously requests writes and m1 continuously requests reads -> grants alternate m0,m1,m0,... with one transfer each per 2 cycles.
REQ-030 m1 reads with lock=1, then writes with lock=0 while m0 requests throughout -> m0 waitrequest=1 until the cycle after m1's unlocked write, then m0 is granted.
REQ-031 m0 locks then idles for 64 cycles while m1 requests -> m1 is granted in cycle 65 after the lock and lock_timeout=1.
REQ-032 m0 writes 0xDEADBEEF_CAFEF00D to addr 127 with byteenable 0x0F, then reads -> readdata[31:0]=0xCAFEF00D and the upper bytes are unchanged.
REQ-033 Reset asserted one cycle after a granted read -> no readdatavalid, and all outputs hold their reset values from REQ-025.
